// File: rtl/noc_output_vc_arbiter.sv
// noc_output_vc_arbiter: round-robin switch arbiter with per-VC wormhole locks and credits. Ports: clk, rst_n, req_i/label_i (per-requester head flit), credit_i (per-VC slot freed), grant_o/grant_valid_o/grant_idx_o (combinational grant), vc_locked_o, credit_cnt_o, err_o (sticky).
module noc_output_vc_arbiter #(
  parameter int IN_PORTS = 5,
  parameter int VC_NUM = 2,
  parameter int BUF_DEPTH = 4,
  localparam int N = IN_PORTS * VC_NUM,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic [2*N-1:0]       label_i,
  input  logic [VC_NUM-1:0]    credit_i,
  output logic [N-1:0]         grant_o,
  output logic                 grant_valid_o,
  output logic [IW-1:0]        grant_idx_o,
  output logic [VC_NUM-1:0]    vc_locked_o,
  output logic [VC_NUM*CW-1:0] credit_cnt_o,
  output logic                 err_o
);
  logic [IW-1:0] rr;
  logic [VC_NUM-1:0] lock;
  logic [IW-1:0] owner [VC_NUM];
  logic [CW-1:0] cred [VC_NUM];
  logic err;
  logic [N-1:0] elig, bad;
  logic [IW-1:0] gidx;
  logic found, gv;
  logic [1:0] glab;
  logic [VC_NUM-1:0] gvc, ovf;
  for (genvar r = 0; r < N; r++) begin : g_req
    localparam int V = r % VC_NUM;
    logic [1:0] lb;
    logic head;
    assign lb = label_i[2*r +: 2];
    assign head = (lb == 2'd0) || (lb == 2'd3);
    assign elig[r] = req_i[r] && (cred[V] != '0) && (head ? !lock[V] : (lock[V] && owner[V] == IW'(r)));
    assign bad[r] = req_i[r] && !head && !lock[V];
  end
  always_comb begin
    gidx = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && elig[(int'(rr) + i) % N]) begin
        found = 1'b1;
        gidx = IW'((int'(rr) + i) % N);
      end
    end
  end
  // Grant is masked during reset so the crossbar sees no transfer while state is being cleared.
  assign gv = found && rst_n;
  assign glab = label_i[{gidx, 1'b0} +: 2];
  always_comb begin
    gvc = '0;
    ovf = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      gvc[v] = gv && (int'(gidx) % VC_NUM == v);
      ovf[v] = credit_i[v] && !gvc[v] && (cred[v] == CW'(BUF_DEPTH));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
      lock <= '0;
      err <= 1'b0;
      for (int v = 0; v < VC_NUM; v++) begin
        owner[v] <= '0;
        cred[v] <= CW'(BUF_DEPTH);
      end
    end else begin
      if (gv) rr <= (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
      err <= err | (|bad) | (|ovf);
      for (int v = 0; v < VC_NUM; v++) begin
        if (gvc[v] && glab == 2'd0) begin
          lock[v] <= 1'b1;
          owner[v] <= gidx;
        end else if (gvc[v] && glab == 2'd2) begin
          lock[v] <= 1'b0;
        end
        if (gvc[v] && !credit_i[v]) cred[v] <= cred[v] - 1'b1;
        else if (!gvc[v] && credit_i[v] && cred[v] != CW'(BUF_DEPTH)) cred[v] <= cred[v] + 1'b1;
      end
    end
  end
  for (genvar v = 0; v < VC_NUM; v++) begin : g_cred
    assign credit_cnt_o[v*CW +: CW] = cred[v];
  end
  assign grant_o = gv ? N'(1) << gidx : '0;
  assign grant_valid_o = gv;
  assign grant_idx_o = gv ? gidx : '0;
  assign vc_locked_o = lock;
  assign err_o = err;
endmodule

// File: tb/tb_noc_output_vc_arbiter.sv
// tb_noc_output_vc_arbiter: table-driven bench with expected-result queue for noc_output_vc_arbiter.
module tb_noc_output_vc_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] req = '0;
  logic [19:0] lab = '0;
  logic [1:0] cr = '0;
  logic [9:0] grant_o;
  logic grant_valid_o;
  logic [3:0] grant_idx_o;
  logic [1:0] vc_locked_o;
  logic [5:0] credit_cnt_o;
  logic err_o;
  noc_output_vc_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(req),
    .label_i(lab),
    .credit_i(cr),
    .grant_o(grant_o),
    .grant_valid_o(grant_valid_o),
    .grant_idx_o(grant_idx_o),
    .vc_locked_o(vc_locked_o),
    .credit_cnt_o(credit_cnt_o),
    .err_o(err_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic [9:0] req;
    logic [19:0] lab;
    logic [1:0] cr;
    logic gv;
    logic [3:0] gi;
    logic [1:0] lk;
    logic [2:0] c0;
    logic [2:0] c1;
    logic er;
  } vec_t;
  vec_t tv[$];
  vec_t sb[$];
  int checks = 0;
  int failures = 0;
  int cur = 0;
  function automatic vec_t mk(logic rst, logic [9:0] rq, logic [19:0] lb, logic [1:0] c, logic g, int gi, logic [1:0] lk, int c0, int c1, logic er);
    vec_t x;
    x.rst = rst; x.req = rq; x.lab = lb; x.cr = c; x.gv = g; x.gi = 4'(gi);
    x.lk = lk; x.c0 = 3'(c0); x.c1 = 3'(c1); x.er = er;
    return x;
  endfunction
  function automatic logic [19:0] fl(int r, int l);
    logic [19:0] x;
    x = 20'(l) << (2 * r);
    return x;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL v%0d %s actual=%0h required=%0h", cur, nm, act, exp);
    end
  endtask
  task automatic drive(vec_t v);
    req = v.req;
    lab = v.lab;
    cr = v.cr;
    sb.push_back(v);
  endtask
  task automatic compare();
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL v%0d scoreboard actual=empty required=entry", cur);
    end else begin
      e = sb.pop_front();
      chk("grant_o", 32'(grant_o), e.gv ? 32'(1) << e.gi : 32'd0);
      chk("grant_valid", 32'(grant_valid_o), 32'(e.gv));
      chk("grant_idx", 32'(grant_idx_o), e.gv ? 32'(e.gi) : 32'd0);
      chk("vc_locked", 32'(vc_locked_o), 32'(e.lk));
      chk("credit0", 32'(credit_cnt_o[2:0]), 32'(e.c0));
      chk("credit1", 32'(credit_cnt_o[5:3]), 32'(e.c1));
      chk("err", 32'(err_o), 32'(e.er));
    end
    cur++;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    lab = '0;
    cr = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [19:0] ho;
    ho = fl(1,3) | fl(3,3) | fl(5,3) | fl(7,3) | fl(9,3);
    tv.push_back(mk(1, 10'b0000010101, fl(0,3)|fl(2,3)|fl(4,3), 0, 1, 0, 0, 4, 4, 0));
    tv.push_back(mk(0, 10'b0000010101, fl(0,3)|fl(2,3)|fl(4,3), 0, 1, 2, 0, 3, 4, 0));
    tv.push_back(mk(0, 10'b0000010101, fl(0,3)|fl(2,3)|fl(4,3), 0, 1, 4, 0, 2, 4, 0));
    tv.push_back(mk(0, 10'b0000000000, 0, 0, 0, 0, 0, 1, 4, 0));
    tv.push_back(mk(0, 10'b0001000001, fl(0,3)|fl(6,3), 0, 1, 6, 0, 1, 4, 0));
    tv.push_back(mk(1, 10'b0000010100, fl(2,0)|fl(4,0), 0, 1, 2, 0, 4, 4, 0));
    tv.push_back(mk(0, 10'b0000010100, fl(2,1)|fl(4,0), 0, 1, 2, 1, 3, 4, 0));
    tv.push_back(mk(0, 10'b0000010100, fl(2,2)|fl(4,0), 0, 1, 2, 1, 2, 4, 0));
    tv.push_back(mk(0, 10'b0000010000, fl(4,0), 0, 1, 4, 0, 1, 4, 0));
    tv.push_back(mk(0, 10'b0000000000, 0, 0, 0, 0, 1, 0, 4, 0));
    tv.push_back(mk(1, 10'b0000000011, fl(0,0)|fl(1,0), 0, 1, 0, 0, 4, 4, 0));
    tv.push_back(mk(0, 10'b0000000011, fl(0,1)|fl(1,0), 0, 1, 1, 1, 3, 4, 0));
    tv.push_back(mk(0, 10'b0000000011, fl(0,1)|fl(1,1), 0, 1, 0, 3, 3, 3, 0));
    tv.push_back(mk(0, 10'b0000000011, fl(0,2)|fl(1,1), 0, 1, 1, 3, 2, 3, 0));
    tv.push_back(mk(0, 10'b0000000011, fl(0,2)|fl(1,2), 0, 1, 0, 3, 2, 2, 0));
    tv.push_back(mk(0, 10'b0000000010, fl(1,2), 0, 1, 1, 2, 1, 2, 0));
    tv.push_back(mk(0, 10'b0000000000, 0, 0, 0, 0, 0, 1, 1, 0));
    tv.push_back(mk(1, 10'b1010101010, ho, 0, 1, 1, 0, 4, 4, 0));
    tv.push_back(mk(0, 10'b1010101000, ho, 0, 1, 3, 0, 4, 3, 0));
    tv.push_back(mk(0, 10'b1010100000, ho, 0, 1, 5, 0, 4, 2, 0));
    tv.push_back(mk(0, 10'b1010000000, ho, 0, 1, 7, 0, 4, 1, 0));
    tv.push_back(mk(0, 10'b1000000000, ho, 2'b10, 0, 0, 0, 4, 0, 0));
    tv.push_back(mk(0, 10'b1000000000, ho, 0, 1, 9, 0, 4, 1, 0));
    tv.push_back(mk(0, 10'b0000000010, ho, 2'b10, 0, 0, 0, 4, 0, 0));
    tv.push_back(mk(0, 10'b0000000010, ho, 2'b10, 1, 1, 0, 4, 1, 0));
    tv.push_back(mk(0, 10'b0000000000, 0, 0, 0, 0, 0, 4, 1, 0));
    tv.push_back(mk(1, 10'b0000000000, 0, 2'b01, 0, 0, 0, 4, 4, 0));
    tv.push_back(mk(0, 10'b0000000000, 0, 0, 0, 0, 0, 4, 4, 1));
    tv.push_back(mk(1, 10'b0000000001, fl(0,1), 0, 0, 0, 0, 4, 4, 0));
    tv.push_back(mk(0, 10'b0000000001, fl(0,1), 0, 0, 0, 0, 4, 4, 1));
    tv.push_back(mk(0, 10'b0000000000, 0, 0, 0, 0, 0, 4, 4, 1));
    repeat (2) @(negedge clk);
    foreach (tv[k]) begin
      if (tv[k].rst) do_reset();
      drive(tv[k]);
      #2 compare();
      @(negedge clk);
    end
    do_reset();
    drive(mk(0, 10'b0000000001, fl(0,0), 0, 1, 0, 0, 4, 4, 0));
    #2 compare();
    @(negedge clk);
    drive(mk(0, 10'b0000000001, fl(0,1), 0, 1, 0, 1, 3, 4, 0));
    #2 compare();
    @(negedge clk);
    drive(mk(0, 10'b0000000101, fl(0,0)|fl(2,0), 0, 0, 0, 0, 4, 4, 0));
    #2 rst_n = 1'b0;
    #1 compare();
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(0, 10'b0000100000, fl(5,0), 0, 1, 5, 0, 4, 4, 0));
    #2 compare();
    @(negedge clk);
    drive(mk(0, 10'b0000000000, 0, 0, 0, 0, 2, 4, 3, 0));
    #2 compare();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
